// File: rtl/npu_window_pkg.sv
// Shared definitions for the NPU window register path: default widths,
// element-index width helper and the bank selector type.
package npu_window_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int K_DEF      = 3;

  typedef logic bank_sel_t;

  // Index width for a KxK window; never narrower than one bit.
  function automatic int addr_w(input int k);
    int depth;
    depth = k * k;
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/window_bank.sv
// One window bank: DEPTH x WIDTH register array with a synchronous write port
// and two combinational read ports that return 0 for out-of-range indices.
module window_bank #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Window contents are data, not state: deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (32'(raddr_a_i) < DEPTH) ? mem_q[raddr_a_i] : '0;
  assign rdata_b_o = (32'(raddr_b_i) < DEPTH) ? mem_q[raddr_b_i] : '0;

endmodule

// File: rtl/window_bank_reg.sv
// Double-buffered KxK window register: fills a shadow bank from the load
// stream while the other bank streams to the MAC array, with optional reuse.
module window_bank_reg
  import npu_window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = K_DEF,
  parameter int LANES  = 1,
  parameter int ADDR_W = addr_w(K)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DATA_W-1:0]   s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*DATA_W-1:0]   m_data,
  output logic [ADDR_W-1:0]         m_idx,
  output logic                      m_last,
  input  logic                      i_reuse,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  output logic [LANES*DATA_W-1:0]   o_rd_data,
  output logic [1:0]                o_full
);

  localparam int                DEPTH    = K * K;
  localparam int                BEAT_W   = LANES * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [1:0]        full_q, full_d;
  bank_sel_t         wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic              s_fire, m_fire;
  logic [BEAT_W-1:0] strm_data [2];
  logic [BEAT_W-1:0] dbg_data  [2];

  assign s_ready = !full_q[wb_q];
  assign m_valid = full_q[rb_q];
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      window_bank #(
        .WIDTH  (BEAT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_bank (
        .clk_i     (i_clk),
        .we_i      (s_fire && !i_flush && (wb_q == 1'(gi))),
        .waddr_i   (wp_q),
        .wdata_i   (s_data),
        .raddr_a_i (rp_q),
        .rdata_a_o (strm_data[gi]),
        .raddr_b_i (i_rd_addr),
        .rdata_b_o (dbg_data[gi])
      );
    end
  endgenerate

  // Load completion and stream release always hit different banks, so both
  // updates to full_d can be applied in the same cycle.
  always_comb begin
    full_d = full_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (i_flush) begin
      full_d = '0;
      wb_d   = 1'b0;
      rb_d   = 1'b0;
      wp_d   = '0;
      rp_d   = '0;
    end else begin
      if (s_fire) begin
        if (wp_q == LAST_IDX) begin
          full_d[wb_q] = 1'b1;
          wp_d         = '0;
          wb_d         = ~wb_q;
        end else begin
          wp_d = wp_q + ADDR_W'(1);
        end
      end
      if (m_fire) begin
        if (rp_q == LAST_IDX) begin
          rp_d = '0;
          if (!i_reuse) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
          end
        end else begin
          rp_d = rp_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      full_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      full_q <= full_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
    end
  end

  assign m_data    = strm_data[rb_q];
  assign m_idx     = rp_q;
  assign m_last    = m_valid && (rp_q == LAST_IDX);
  assign o_rd_data = dbg_data[rb_q];
  assign o_full    = full_q;

endmodule

// File: tb/tb_window_bank_reg.sv
// Scoreboard bench for window_bank_reg (K=3, LANES=2): stimulus pushes the
// expected output stream, a negedge monitor pops and compares on handshakes.
module tb_window_bank_reg;

  localparam int AW = 4;
  localparam int BW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_flush = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic          i_reuse = 1'b0;
  logic [BW-1:0] s_data = '0;
  logic [AW-1:0] i_rd_addr = '0;
  logic          s_ready, m_valid, m_last;
  logic [BW-1:0] m_data, o_rd_data;
  logic [AW-1:0] m_idx;
  logic [1:0]    o_full;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb_q[$];

  window_bank_reg #(.DATA_W(8), .K(3), .LANES(2), .ADDR_W(AW)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_flush   (i_flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_idx     (m_idx),
    .m_last    (m_last),
    .i_reuse   (i_reuse),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data),
    .o_full    (o_full)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%h t=%0t", name, act, $time);
    end
  endtask

  // Monitor: one comparison per output handshake.
  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (i_rst_n && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%h/%0d/%b required=none", m_data, m_idx, m_last);
      end else begin
        e = sb_q.pop_front();
        chk("out_elem", {11'b0, m_data, m_idx, m_last}, {11'b0, e});
      end
    end
  end

  task automatic send_beat(input logic [15:0] d);
    int  n;
    bit  done;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge i_clk);
      if (s_ready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 300) begin
          checks++;
          failures++;
          $display("FAIL load_timeout actual=no_ready required=ready beat=%h", d);
          done = 1'b1;
        end
      end
    end
    @(posedge i_clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic push_win(input logic [8:0][15:0] w);
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back({w[i], 4'(i), (i == 8)});
    end
  endtask

  task automatic send_win(input logic [8:0][15:0] w);
    push_win(w);
    for (int i = 0; i < 9; i++) begin
      send_beat(w[i]);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(posedge i_clk);
      n++;
    end while (sb_q.size() > 0 && n < 300);
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  function automatic logic [8:0][15:0] mkwin(input int base, input int step);
    logic [8:0][15:0] w;
    logic [7:0] lo;
    for (int i = 0; i < 9; i++) begin
      lo   = 8'(base + step * i);
      w[i] = {lo ^ 8'h5A, lo};
    end
    return w;
  endfunction

  byte unsigned pat1 [9] = '{3, 1, 5, 2, 4, 2, 5, 1, 3};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [8:0][15:0] w;
    logic [15:0] prev;
    logic [3:0]  prev_idx;
    bit          prev_stall;
    int          vc, lc;
    bit          clr_reuse;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_idx", 32'(m_idx), 32'd0);
    chk("rst_o_full", 32'(o_full), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Basic load and stream
    for (int i = 0; i < 9; i++) begin
      w[i] = {8'(pat1[i]) ^ 8'h5A, 8'(pat1[i])};
    end
    m_ready = 1'b1;
    send_win(w);
    chk("basic_valid_after_last", 32'(m_valid), 32'd1);
    chk("basic_full_bank0", 32'(o_full), 32'd1);
    wait_drain();
    chk("basic_valid_dropped", 32'(m_valid), 32'd0);
    chk("basic_full_clear", 32'(o_full), 32'd0);

    // Both banks full under backpressure, then gapless drain
    m_ready = 1'b0;
    send_win(mkwin(0, 1));
    send_win(mkwin(9, 1));
    chk("both_s_ready", 32'(s_ready), 32'd0);
    chk("both_o_full", 32'(o_full), 32'd3);
    m_ready = 1'b1;
    vc = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge i_clk);
      if (m_valid) vc++;
    end
    chk("both_no_bubble", 32'(vc), 32'd18);
    wait_drain();
    chk("both_full_clear", 32'(o_full), 32'd0);

    // Reuse: two passes of one window
    m_ready = 1'b0;
    w = mkwin(8'h20, 3);
    send_win(w);
    push_win(w);
    m_ready   = 1'b1;
    i_reuse   = 1'b1;
    vc        = 0;
    lc        = 0;
    for (int c = 0; c < 18; c++) begin
      clr_reuse = 1'b0;
      @(negedge i_clk);
      if (m_valid) vc++;
      if (m_valid && m_last) begin
        lc++;
        clr_reuse = 1'b1;
      end
      @(posedge i_clk);
      #1;
      if (clr_reuse) i_reuse = 1'b0;
    end
    chk("reuse_valid_cycles", 32'(vc), 32'd18);
    chk("reuse_last_count", 32'(lc), 32'd2);
    chk("reuse_drain_empty", 32'(sb_q.size()), 32'd0);
    chk("reuse_valid_dropped", 32'(m_valid), 32'd0);
    chk("reuse_full_clear", 32'(o_full), 32'd0);

    // Backpressure pattern 1,0,0,1
    m_ready = 1'b0;
    send_win(mkwin(8'h40, 1));
    prev_stall = 1'b0;
    prev       = '0;
    prev_idx   = '0;
    for (int c = 0; c < 200 && sb_q.size() > 0; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      @(negedge i_clk);
      if (prev_stall) begin
        chk("bp_hold", {12'b0, m_data, m_idx}, {12'b0, prev, prev_idx});
      end
      prev_stall = m_valid && !m_ready;
      prev       = m_data;
      prev_idx   = m_idx;
      @(posedge i_clk);
      #1;
    end
    chk("bp_drain_empty", 32'(sb_q.size()), 32'd0);
    chk("bp_valid_dropped", 32'(m_valid), 32'd0);

    // Flush after a partial load; the flush-cycle beat must be dropped
    m_ready = 1'b1;
    w = mkwin(8'hF0, 1);
    for (int i = 0; i < 4; i++) begin
      send_beat(w[i]);
    end
    i_flush = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_o_full", 32'(o_full), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    send_win(mkwin(8'h60, 7));
    wait_drain();
    chk("flush_full_clear", 32'(o_full), 32'd0);

    // Async reset mid-stream
    m_ready = 1'b0;
    send_win(mkwin(8'h80, 1));
    m_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_m_last", 32'(m_last), 32'd0);
    chk("rst_mid_m_idx", 32'(m_idx), 32'd0);
    chk("rst_mid_s_ready", 32'(s_ready), 32'd1);
    chk("rst_mid_o_full", 32'(o_full), 32'd0);
    chk("rst_mid_left", 32'(sb_q.size()), 32'd6);
    sb_q.delete();
    m_ready = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Random-access port on the active bank
    for (int i = 0; i < 9; i++) begin
      w[i] = {8'(8'hA0 + i), 8'(8'h10 + i)};
    end
    send_win(w);
    i_rd_addr = 4'd4;
    #1;
    chk("rd_addr4", 32'(o_rd_data), 32'h0000A414);
    i_rd_addr = 4'd0;
    #1;
    chk("rd_addr0", 32'(o_rd_data), 32'h0000A010);
    i_rd_addr = 4'd8;
    #1;
    chk("rd_addr8", 32'(o_rd_data), 32'h0000A818);
    i_rd_addr = 4'd12;
    #1;
    chk("rd_addr12", 32'(o_rd_data), 32'h00000000);
    i_rd_addr = 4'd0;
    @(posedge i_clk);
    #1;
    m_ready = 1'b1;
    wait_drain();
    chk("rd_full_clear", 32'(o_full), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
